// File: rtl/test_signal_generator.sv
// Programmable square-wave source with exact high/low cycle counts, double-buffered config and N-period bursts.
// sig_out is registered; a config change takes effect only at a period boundary, so no partial phase is ever emitted.
module test_signal_generator #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_high_time,
  input  logic [CNT_W-1:0]   cfg_low_time,
  input  logic [BURST_W-1:0] cfg_burst_count,
  output logic               sig_out,
  output logic               period_start,
  output logic               burst_done,
  output logic               cfg_error,
  output logic               busy,
  output logic [31:0]        periods_generated
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   act_high, act_high_n, act_low, act_low_n;
  logic [BURST_W-1:0] act_burst, act_burst_n;
  logic [CNT_W-1:0]   shd_high, shd_high_n, shd_low, shd_low_n;
  logic [BURST_W-1:0] shd_burst, shd_burst_n;
  logic               pending, pending_n;
  logic               armed, armed_n;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_n, burst_inc;
  logic [31:0]        pg_n, pg_sat;
  logic               period_start_n, burst_done_n, cfg_error_n;

  logic accept, cfg_ok, take, boundary, direct, to_shadow, apply_pend, applied;

  assign cfg_ready  = ~pending;
  assign busy       = (state != IDLE);
  assign accept     = cfg_valid && cfg_ready;
  assign cfg_ok     = (cfg_high_time != '0) && (cfg_low_time != '0);
  assign take       = accept && cfg_ok;
  assign boundary   = (state == LOW) && (cnt == CNT_W'(1));
  // A config accepted on a boundary edge skips the shadow and drives the period that starts there.
  assign direct     = take && ((state == IDLE) || boundary);
  assign to_shadow  = take && !direct;
  assign apply_pend = boundary && pending;
  assign applied    = direct || apply_pend;
  assign burst_inc  = burst_cnt + BURST_W'(1);
  assign pg_sat     = (periods_generated == '1) ? periods_generated : periods_generated + 32'd1;

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    act_high_n     = act_high;
    act_low_n      = act_low;
    act_burst_n    = act_burst;
    shd_high_n     = shd_high;
    shd_low_n      = shd_low;
    shd_burst_n    = shd_burst;
    pending_n      = pending;
    armed_n        = armed;
    burst_cnt_n    = burst_cnt;
    pg_n           = periods_generated;
    period_start_n = 1'b0;
    burst_done_n   = 1'b0;
    cfg_error_n    = accept && !cfg_ok;

    if (to_shadow) begin
      shd_high_n  = cfg_high_time;
      shd_low_n   = cfg_low_time;
      shd_burst_n = cfg_burst_count;
      pending_n   = 1'b1;
    end

    if (direct) begin
      act_high_n  = cfg_high_time;
      act_low_n   = cfg_low_time;
      act_burst_n = cfg_burst_count;
    end else if (apply_pend) begin
      act_high_n  = shd_high;
      act_low_n   = shd_low;
      act_burst_n = shd_burst;
      pending_n   = 1'b0;
    end

    if (applied) begin
      pg_n        = '0;
      burst_cnt_n = '0;
      armed_n     = 1'b1;
    end

    case (state)
      IDLE: begin
        if (enable && armed) begin
          state_n        = HIGH;
          cnt_n          = act_high_n;
          period_start_n = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == CNT_W'(1)) begin
          state_n = LOW;
          cnt_n   = act_low;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (!boundary) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          // A freshly applied config restarts both counters, so the old burst target no longer applies.
          if (!applied) begin
            pg_n        = pg_sat;
            burst_cnt_n = burst_inc;
          end
          if (!applied && (act_burst != '0) && (burst_inc == act_burst)) begin
            burst_done_n = 1'b1;
            armed_n      = 1'b0;
            state_n      = IDLE;
          end else if (enable) begin
            state_n        = HIGH;
            cnt_n          = act_high_n;
            period_start_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      act_high          <= '0;
      act_low           <= '0;
      act_burst         <= '0;
      shd_high          <= '0;
      shd_low           <= '0;
      shd_burst         <= '0;
      pending           <= 1'b0;
      armed             <= 1'b0;
      burst_cnt         <= '0;
      periods_generated <= '0;
      sig_out           <= 1'b0;
      period_start      <= 1'b0;
      burst_done        <= 1'b0;
      cfg_error         <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      act_high          <= act_high_n;
      act_low           <= act_low_n;
      act_burst         <= act_burst_n;
      shd_high          <= shd_high_n;
      shd_low           <= shd_low_n;
      shd_burst         <= shd_burst_n;
      pending           <= pending_n;
      armed             <= armed_n;
      burst_cnt         <= burst_cnt_n;
      periods_generated <= pg_n;
      sig_out           <= (state_n == HIGH);
      period_start      <= period_start_n;
      burst_done        <= burst_done_n;
      cfg_error         <= cfg_error_n;
    end
  end

endmodule

// File: tb/tb_test_signal_generator.sv
// Bench for test_signal_generator: directed scenarios plus random traffic against a period-position reference model.
module tb_test_signal_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_high_time = '0;
  logic [31:0] cfg_low_time = '0;
  logic [15:0] cfg_burst_count = '0;
  logic        cfg_ready, sig_out, period_start, burst_done, cfg_error, busy;
  logic [31:0] periods_generated;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  test_signal_generator #(.CNT_W(32), .BURST_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_high_time(cfg_high_time), .cfg_low_time(cfg_low_time),
    .cfg_burst_count(cfg_burst_count),
    .sig_out(sig_out), .period_start(period_start), .burst_done(burst_done),
    .cfg_error(cfg_error), .busy(busy), .periods_generated(periods_generated)
  );

  always #5 clk = ~clk;

  // Reference model: running flag plus position inside the current period.
  bit              m_run, m_pend, m_armed, m_bd, m_err;
  longint unsigned m_pos;
  logic [31:0]     m_h, m_l, s_h, s_l, m_pg;
  logic [15:0]     m_b, s_b;
  int              m_bc;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_armed = 0; m_bd = 0; m_err = 0; m_pos = 0;
    m_h = 0; m_l = 0; m_b = 0; s_h = 0; s_l = 0; s_b = 0; m_pg = 0; m_bc = 0;
  endtask

  task automatic model_apply(input logic [31:0] h, input logic [31:0] l, input logic [15:0] b);
    m_h = h; m_l = l; m_b = b; m_pg = 0; m_bc = 0; m_armed = 1;
  endtask

  task automatic model_step();
    bit acc, ok, take, bnd, done, was_armed;
    acc  = cfg_valid && !m_pend;
    ok   = (cfg_high_time != 0) && (cfg_low_time != 0);
    take = acc && ok;
    m_err = acc && !ok;
    m_bd  = 0;
    bnd  = m_run && (m_pos == 64'(m_h) + 64'(m_l) - 1);
    if (m_run && !bnd) begin
      m_pos++;
      if (take) begin
        s_h = cfg_high_time; s_l = cfg_low_time; s_b = cfg_burst_count; m_pend = 1;
      end
    end else if (m_run) begin
      done = 0;
      if (take) model_apply(cfg_high_time, cfg_low_time, cfg_burst_count);
      else if (m_pend) begin
        model_apply(s_h, s_l, s_b);
        m_pend = 0;
      end else begin
        if (m_pg != 32'hFFFF_FFFF) m_pg++;
        m_bc++;
        if (m_b != 0 && m_bc == int'(m_b)) begin
          m_bd = 1; m_armed = 0; m_run = 0; done = 1;
        end
      end
      if (!done) begin
        m_run = enable;
        m_pos = 0;
      end
    end else begin
      was_armed = m_armed;
      if (take) model_apply(cfg_high_time, cfg_low_time, cfg_burst_count);
      if (was_armed && enable) begin
        m_run = 1;
        m_pos = 0;
      end
    end
  endtask

  function automatic logic [37:0] expv();
    return {m_run && (m_pos < 64'(m_h)), m_run && (m_pos == 0), m_bd, m_err, m_run, !m_pend, m_pg};
  endfunction

  function automatic logic [37:0] obs();
    return {sig_out, period_start, burst_done, cfg_error, busy, cfg_ready, periods_generated};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    enable = 1'b0;
    cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] h, input logic [31:0] l, input logic [15:0] b);
    cfg_high_time = h; cfg_low_time = l; cfg_burst_count = b; cfg_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #3;
    n_cmp++;
    if (obs() !== {6'b000001, 32'd0}) begin
      n_bad++; $display("FAIL reset_values got=%h exp=%h", obs(), {6'b000001, 32'd0});
    end
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_continuous();
    do_reset();
    enable = 1'b1;
    set_cfg(3, 5, 0);
    tick();
    cfg_valid = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL continuous cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      tick();
    end
    n_cmp++;
    if (periods_generated !== 32'd4 || period_start !== 1'b1) begin
      n_bad++; $display("FAIL continuous_count got=%0d/%b exp=4/1", periods_generated, period_start);
    end
  endtask

  task automatic test_burst();
    do_reset();
    enable = 1'b1;
    set_cfg(2, 2, 3);
    tick();
    cfg_valid = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL burst cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      tick();
    end
    n_cmp++;
    if ({burst_done, busy, sig_out} !== 3'b100 || periods_generated !== 32'd3) begin
      n_bad++; $display("FAIL burst_end got=%b/%0d exp=100/3", {burst_done, busy, sig_out}, periods_generated);
    end
    tick();
    n_cmp++;
    if ({burst_done, busy, sig_out} !== 3'b000) begin
      n_bad++; $display("FAIL burst_single_pulse got=%b exp=000", {burst_done, busy, sig_out});
    end
  endtask

  task automatic test_mid_change();
    do_reset();
    enable = 1'b1;
    set_cfg(4, 4, 0);
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    set_cfg(1, 1, 0);
    tick();
    n_cmp++;
    if (cfg_ready !== 1'b0 || sig_out !== 1'b1) begin
      n_bad++; $display("FAIL mid_shadow got=%b%b exp=01", cfg_ready, sig_out);
    end
    set_cfg(2, 3, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL mid_change cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    n_cmp++;
    if ({sig_out, period_start, cfg_ready} !== 3'b111 || periods_generated !== 32'd0) begin
      n_bad++; $display("FAIL mid_apply got=%b/%0d exp=111/0", {sig_out, period_start, cfg_ready}, periods_generated);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) cfg_valid = 1'b0;
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL mid_after cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_reject();
    do_reset();
    enable = 1'b1;
    set_cfg(2, 3, 0);
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();
    set_cfg(0, 7, 0);
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_error !== 1'b1 || cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL reject_pulse got=%b%b exp=11", cfg_error, cfg_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL reject cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1;
    set_cfg(5, 5, 0);
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL enable_drop cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    n_cmp++;
    if ({busy, sig_out} !== 2'b00 || periods_generated !== 32'd1) begin
      n_bad++; $display("FAIL enable_stop got=%b/%0d exp=00/1", {busy, sig_out}, periods_generated);
    end
    repeat (3) tick();
    enable = 1'b1;
    tick();
    n_cmp++;
    if ({sig_out, period_start, busy} !== 3'b111) begin
      n_bad++; $display("FAIL enable_restart got=%b exp=111", {sig_out, period_start, busy});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    set_cfg(100, 100, 0);
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL reset_mid_run cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (obs() !== {6'b000001, 32'd0}) begin
      n_bad++; $display("FAIL reset_mid_async got=%h exp=%h", obs(), {6'b000001, 32'd0});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL reset_mid_idle cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    set_cfg(3, 3, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      cfg_valid = 1'b0;
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable          = ($urandom_range(0, 9) != 0);
      cfg_valid       = ($urandom_range(0, 7) == 0);
      cfg_high_time   = $urandom_range(0, 5);
      cfg_low_time    = $urandom_range(0, 5);
      cfg_burst_count = 16'($urandom_range(0, 3));
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_mid_change();
    test_reject();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/test_signal_generator.md
Name: test_signal_generator

Overview:
Programmable square-wave source that produces a signal with exact high and low durations, counted in clk cycles. It is the transmit-side counterpart of the frequency/period measurement path: its output drives the high/low-time measurement front end in loopback and self-test. Configuration is double-buffered, so timing changes take effect only at period boundaries and no glitch reaches sig_out. It supports continuous output and N-period bursts.

Parameters:
CNT_W, 32, width of the high/low time configuration fields and of the internal phase counter
BURST_W, 16, width of the burst count field

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
enable  input  1  run permission; sampled at every period boundary
cfg_valid  input  1  configuration offer
cfg_ready  output  1  configuration can be accepted; accept = cfg_valid && cfg_ready at a rising edge
cfg_high_time  input  CNT_W  high phase length, in cycles
cfg_low_time  input  CNT_W  low phase length, in cycles
cfg_burst_count  input  BURST_W  number of periods to emit; 0 = continuous
sig_out  output  1  generated signal, registered
period_start  output  1  one-cycle pulse coincident with the first high cycle of each period
burst_done  output  1  one-cycle pulse when the last burst period completes
cfg_error  output  1  one-cycle pulse when an offered config is rejected
busy  output  1  state is not IDLE
periods_generated  output  32  periods completed since the last config was applied; saturates at 2^32-1

Behaviour:
- Reset, asynchronous:
  - sig_out=0, period_start=0, burst_done=0, cfg_error=0, busy=0, periods_generated=0, cfg_ready=1.
  - Active and shadow configs cleared; armed=0; pending=0; state IDLE.
  - Reset mid-period forces sig_out low immediately.
- Registers:
  - Active config: act_high, act_low, act_burst.
  - Shadow config: one-deep, plus a pending flag. cfg_ready = ~pending.
  - armed flag.
- Config validation at acceptance:
  - If cfg_high_time==0 or cfg_low_time==0: pulse cfg_error the next cycle, discard the config, leave state unchanged.
- Config application:
  - Accepted in IDLE: written directly to active at the acceptance edge; periods_generated cleared; armed=1.
  - Accepted while HIGH/LOW: stored in shadow, pending=1. Applied at the next period boundary, which clears pending, clears periods_generated and sets armed=1.
  - Accepted on the same edge as a boundary: bypasses the shadow and is active for the period starting at that edge.
- States:
  - IDLE: sig_out=0. When enable && armed, go to HIGH at the next edge (sig_out first high one cycle after acceptance at the earliest). period_start=1 in that first HIGH cycle. Phase counter loads act_high.
  - HIGH: sig_out=1 for exactly act_high cycles, then LOW. Phase counter loads act_low.
  - LOW: sig_out=0 for exactly act_low cycles. The last LOW cycle is the boundary. At the boundary edge:
    - periods_generated increments, saturating.
    - A pending config is applied.
    - If burst mode and the completed count reaches act_burst: burst_done pulses in the next cycle, armed=0, go to IDLE.
    - Else if enable=1: go to HIGH with period_start.
    - Else: go to IDLE with armed retained.
- Period and phase rules:
  - Period is exactly act_high+act_low cycles.
  - The phase counter counts down from the loaded value to 1. All arithmetic is unsigned CNT_W.
- Mid-period changes:
  - Deasserting enable mid-period never truncates the period. The current period finishes and the block stops at the boundary.
  - A burst count is tracked internally. It is reset whenever a config is applied.
- A new config arriving after burst_done re-arms the block. If enable=1, output restarts.
- busy=1 in HIGH/LOW and 0 in IDLE.

Test Plan:
- Config high=3, low=5, burst=0, enable=1 -> sig_out pattern 1,1,1,0,0,0,0,0 repeating; period_start every 8 cycles; periods_generated=4 after 32 cycles.
- Config high=2, low=2, burst=3 -> exactly 3 periods (12 cycles); burst_done pulses once one cycle after the 12th cycle; busy then 0, sig_out 0; periods_generated=3.
- Running high=4, low=4; offer high=1, low=1 mid HIGH -> accepted, cfg_ready=0 until the boundary; the current 8-cycle period completes unchanged; then a 1/1 pattern; periods_generated restarts from 0; a second offer before the boundary stalls (cfg_ready=0).
- Offer high=0, low=7 -> cfg_error one-cycle pulse; output and active config unchanged; cfg_ready stays 1.
- Running high=5, low=5; drop enable in cycle 2 of HIGH -> the period completes (10 cycles total), then IDLE with sig_out=0; re-asserting enable restarts with period_start and no new config needed.
- Assert rst during HIGH of a high=100, low=100 run -> sig_out falls without waiting for clk; all outputs at reset values; no restart after rst release until a new config is accepted.
